ball_split_scheduler: RTL
=========================

Name: ball_split_scheduler

Overview:
Sequences the pool of bouncing-ball trajectory generators for one level. Spawns the first ball when a level starts. On each player hit it splits the hit ball into two smaller children by issuing per-slot load commands (initial position and speed), or removes it if it is already the smallest size. Tracks which slots are alive and signals when the level is cleared. Sits between the collision/hit logic and the array of ball trajectory instances.

Parameters:
NUM_SLOTS, 8, number of ball trajectory instances managed (2..16)
SLOT_W, 3, index width, equal to clog2(NUM_SLOTS)
MAX_SIZE, 3, size code of the smallest ball; size 0 is the largest
START_X, 100, first-ball initial X in pixels
START_Y, 50, first-ball initial Y in pixels
START_XSPEED, 64, first-ball X speed in sub-pixel units (1/64 px per frame)
SPLIT_XSPEED, 96, magnitude of child X speed
SPLIT_YSPEED, 200, magnitude of child upward Y speed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame; used only to time all_cleared
start_level  in  1  pulse; spawns the first ball (accepted only in IDLE)
hit_valid  in  1  a ball was hit this cycle
hit_slot  in  SLOT_W  index of the hit ball
hit_x  in  11  topLeftX of the hit ball, pixels
hit_y  in  11  topLeftY of the hit ball, pixels
hit_ready  out  1  high only in RUN; a hit is accepted when hit_valid && hit_ready
load_valid  out  1  one-cycle pulse: load the slot below with initial values
load_slot  out  SLOT_W  target slot of the load
load_x  out  11  initialX for the target
load_y  out  11  initialY for the target
load_xspeed  out  11  initialXspeed, two's complement
load_yspeed  out  11  initialYspeed, two's complement
load_size  out  2  size code for the target
slot_active  out  NUM_SLOTS  alive mask, one bit per slot
slot_size  out  2*NUM_SLOTS  packed size code per slot; slot i is bits [2i+1:2i]
overflow  out  1  one-cycle pulse: child B was dropped because no slot was free
all_cleared  out  1  one-cycle pulse: the level is cleared

Behaviour:
- Reset (synchronous, highest priority, also applies mid-operation):
  - state goes to IDLE; slot_active=0; slot_size=0.
  - load_valid=0; all load_* fields=0; hit_ready=0; overflow=0; all_cleared=0.
  - Any pending split is discarded.
- States: IDLE, SPAWN, RUN, LOAD_A, LOAD_B, KILL, CLEAR.
- IDLE:
  - start_level moves to SPAWN; hit_valid is ignored.
- SPAWN (1 cycle):
  - load_valid=1, slot 0, START_X, START_Y, xspeed=START_XSPEED, yspeed=0, size 0.
  - Sets slot_active[0] and clears all other slots. Next state is RUN.
- RUN:
  - hit_ready=1. start_level is ignored.
  - On an accepted hit whose slot is inactive, the hit is dropped and the state stays RUN.
  - On an accepted hit on an active slot, latch slot, x, y and size.
  - If size==MAX_SIZE, go to KILL; otherwise go to LOAD_A.
- KILL (1 cycle):
  - Clears slot_active[hit_slot]; no load. Next state is RUN, or CLEAR if the mask becomes 0.
- LOAD_A (1 cycle, accept+1):
  - load_valid=1; load_slot=hit_slot (the hit slot is reused).
  - x=hit_x, y=hit_y, xspeed=-SPLIT_XSPEED, yspeed=-SPLIT_YSPEED, size=latched+1.
  - Updates slot_size. Also selects the lowest-index inactive slot as child B, registered.
- LOAD_B (1 cycle, accept+2):
  - If a free slot was found: load_valid=1 to that slot, same fields except xspeed=+SPLIT_XSPEED; set its active bit and size.
  - If none was found: load_valid=0 and overflow=1.
  - Next state is RUN. Throughput is at most one hit per 3 cycles.
- CLEAR:
  - Waits for the next startOfFrame, then pulses all_cleared for 1 cycle. Next state is IDLE.
- load_* fields:
  - Registered; they hold their last value when load_valid=0.
  - Speeds are sign-extended 11-bit two's complement.
- Hits are never queued. hit_valid while hit_ready=0 is dropped silently.

Test Plan:
- reset, start_level -> in SPAWN: load_valid on slot 0 with (100,50,64,0) size 0; slot_active=0x01; hit_ready=1 the next cycle.
- In RUN, hit slot 0 at (200,300) -> accept+1: load slot 0, xspeed=-96 (0x7A0), yspeed=-200 (0x738), size 1; accept+2: load slot 1, xspeed=+96; slot_active=0x03; no overflow.
- Hit a slot whose size=3 while it is the only active slot -> KILL, slot_active=0. all_cleared pulses 1 cycle in the cycle after the next startOfFrame, then IDLE.
- Fill all 8 slots, then hit an active size-1 slot -> LOAD_A loads the hit slot with size 2; LOAD_B gives overflow=1 and load_valid=0; slot_active stays 0xFF.
- hit_valid during LOAD_A, and a hit on an inactive slot in RUN -> both ignored; no load_valid; slot_active unchanged.
- Assert reset in LOAD_A -> next cycle: all outputs zero, state IDLE; a following hit_valid is ignored until start_level.

Source files
------------

// File: rtl/ball_split_scheduler_if.sv
// Handshake bundle between the hit/collision logic, the ball split scheduler
// and the array of ball trajectory instances it loads.
interface ball_split_scheduler_if #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
);
  logic                   startOfFrame;
  logic                   start_level;
  logic                   hit_valid;
  logic [SLOT_W-1:0]      hit_slot;
  logic [10:0]            hit_x;
  logic [10:0]            hit_y;
  logic                   hit_ready;
  logic                   load_valid;
  logic [SLOT_W-1:0]      load_slot;
  logic [10:0]            load_x;
  logic [10:0]            load_y;
  logic [10:0]            load_xspeed;
  logic [10:0]            load_yspeed;
  logic [1:0]             load_size;
  logic [NUM_SLOTS-1:0]   slot_active;
  logic [2*NUM_SLOTS-1:0] slot_size;
  logic                   overflow;
  logic                   all_cleared;

  // The scheduler side.
  modport slave (
    input  startOfFrame, start_level, hit_valid, hit_slot, hit_x, hit_y,
    output hit_ready, load_valid, load_slot, load_x, load_y, load_xspeed,
           load_yspeed, load_size, slot_active, slot_size, overflow, all_cleared
  );

  // The side that reports hits and consumes load commands.
  modport master (
    output startOfFrame, start_level, hit_valid, hit_slot, hit_x, hit_y,
    input  hit_ready, load_valid, load_slot, load_x, load_y, load_xspeed,
           load_yspeed, load_size, slot_active, slot_size, overflow, all_cleared
  );
endinterface

// File: rtl/ball_split_scheduler.sv
// Spawns, splits and removes bouncing balls across a pool of trajectory slots,
// and reports when every ball of the level has been destroyed.
module ball_split_scheduler #(
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_W       = 3,
  parameter int MAX_SIZE     = 3,
  parameter int START_X      = 100,
  parameter int START_Y      = 50,
  parameter int START_XSPEED = 64,
  parameter int SPLIT_XSPEED = 96,
  parameter int SPLIT_YSPEED = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  ball_split_scheduler_if.slave bus
);

  localparam logic [10:0] X0      = 11'(START_X);
  localparam logic [10:0] Y0      = 11'(START_Y);
  localparam logic [10:0] XS0     = 11'(START_XSPEED);
  localparam logic [10:0] XS_POS  = 11'(SPLIT_XSPEED);
  localparam logic [10:0] XS_NEG  = 11'(-SPLIT_XSPEED);
  localparam logic [10:0] YS_NEG  = 11'(-SPLIT_YSPEED);
  localparam logic [1:0]  SMALLEST = 2'(MAX_SIZE);

  typedef enum logic [2:0] {IDLE, SPAWN, RUN, LOAD_A, LOAD_B, KILL, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   active_q, active_d;
  logic [2*NUM_SLOTS-1:0] size_q, size_d;
  logic [SLOT_W-1:0]      hslot_q, hslot_d;
  logic [10:0]            hx_q, hx_d;
  logic [10:0]            hy_q, hy_d;
  logic [1:0]             csize_q, csize_d;
  logic                   lvalid_q, lvalid_d;
  logic [SLOT_W-1:0]      lslot_q, lslot_d;
  logic [10:0]            lx_q, lx_d;
  logic [10:0]            ly_q, ly_d;
  logic [10:0]            lxs_q, lxs_d;
  logic [10:0]            lys_q, lys_d;
  logic [1:0]             lsize_q, lsize_d;
  logic                   ovf_q, ovf_d;
  logic                   clr_q, clr_d;

  logic                   hit_in_range;
  logic [SLOT_W:0]        hit_base;
  logic [1:0]             hit_size;
  logic                   free_found;
  logic [SLOT_W-1:0]      free_idx;
  logic [SLOT_W:0]        free_base;

  assign hit_in_range = {1'b0, bus.hit_slot} < (SLOT_W+1)'(NUM_SLOTS);
  assign hit_base     = {bus.hit_slot, 1'b0};
  assign hit_size     = size_q[hit_base +: 2];
  assign free_base    = {free_idx, 1'b0};

  // Lowest-index dead slot becomes the home of the second child.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    size_d   = size_q;
    hslot_d  = hslot_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    csize_d  = csize_q;
    lvalid_d = 1'b0;
    lslot_d  = lslot_q;
    lx_d     = lx_q;
    ly_d     = ly_q;
    lxs_d    = lxs_q;
    lys_d    = lys_q;
    lsize_d  = lsize_q;
    ovf_d    = 1'b0;
    clr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_level) begin
          state_d     = SPAWN;
          lvalid_d    = 1'b1;
          lslot_d     = '0;
          lx_d        = X0;
          ly_d        = Y0;
          lxs_d       = XS0;
          lys_d       = '0;
          lsize_d     = '0;
          active_d    = '0;
          active_d[0] = 1'b1;
          size_d      = '0;
        end
      end

      SPAWN: state_d = RUN;

      // Load outputs are registered, so child A is issued on the accepting edge.
      RUN: begin
        if (bus.hit_valid && hit_in_range && active_q[bus.hit_slot]) begin
          hslot_d = bus.hit_slot;
          hx_d    = bus.hit_x;
          hy_d    = bus.hit_y;
          if (hit_size == SMALLEST) begin
            state_d = KILL;
          end else begin
            state_d               = LOAD_A;
            csize_d               = hit_size + 2'd1;
            size_d[hit_base +: 2] = hit_size + 2'd1;
            lvalid_d              = 1'b1;
            lslot_d               = bus.hit_slot;
            lx_d                  = bus.hit_x;
            ly_d                  = bus.hit_y;
            lxs_d                 = XS_NEG;
            lys_d                 = YS_NEG;
            lsize_d               = hit_size + 2'd1;
          end
        end
      end

      LOAD_A: begin
        state_d = LOAD_B;
        if (free_found) begin
          lvalid_d               = 1'b1;
          lslot_d                = free_idx;
          lx_d                   = hx_q;
          ly_d                   = hy_q;
          lxs_d                  = XS_POS;
          lys_d                  = YS_NEG;
          lsize_d                = csize_q;
          active_d[free_idx]     = 1'b1;
          size_d[free_base +: 2] = csize_q;
        end else begin
          ovf_d = 1'b1;
        end
      end

      LOAD_B: state_d = RUN;

      KILL: begin
        active_d[hslot_q] = 1'b0;
        state_d           = (active_d == '0) ? CLEAR : RUN;
      end

      CLEAR: begin
        if (bus.startOfFrame) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      size_q   <= '0;
      hslot_q  <= '0;
      hx_q     <= '0;
      hy_q     <= '0;
      csize_q  <= '0;
      lvalid_q <= 1'b0;
      lslot_q  <= '0;
      lx_q     <= '0;
      ly_q     <= '0;
      lxs_q    <= '0;
      lys_q    <= '0;
      lsize_q  <= '0;
      ovf_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      size_q   <= size_d;
      hslot_q  <= hslot_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      csize_q  <= csize_d;
      lvalid_q <= lvalid_d;
      lslot_q  <= lslot_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      lxs_q    <= lxs_d;
      lys_q    <= lys_d;
      lsize_q  <= lsize_d;
      ovf_q    <= ovf_d;
      clr_q    <= clr_d;
    end
  end

  assign bus.hit_ready   = (state_q == RUN);
  assign bus.load_valid  = lvalid_q;
  assign bus.load_slot   = lslot_q;
  assign bus.load_x      = lx_q;
  assign bus.load_y      = ly_q;
  assign bus.load_xspeed = lxs_q;
  assign bus.load_yspeed = lys_q;
  assign bus.load_size   = lsize_q;
  assign bus.slot_active = active_q;
  assign bus.slot_size   = size_q;
  assign bus.overflow    = ovf_q;
  assign bus.all_cleared = clr_q;

endmodule
